dvi_pll_lock_supervisor: RTL
============================

Name: dvi_pll_lock_supervisor

Overview:
- Watches the DVI PLL `locked` output on the 50 MHz board clock.
- Sequences a clean reset for the video and CPU logic: holds `sys_rst` high until lock has been stable for a programmable time, and reasserts it as soon as lock is lost.
- Counts lock-loss events and optionally kicks the PLL reset if lock never arrives.
- Sits between the PLL instance and the top-level reset distribution in the board wrapper.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the `pll_locked` synchronizer (minimum 2).
- STABLE_CYCLES, 50000, consecutive synchronized-lock cycles required before release (1 ms at 50 MHz); minimum 2.
- TIMEOUT_CYCLES, 500000, WAIT_LOCK cycles before a PLL reset is issued (watchdog only).
- PLL_RST_CYCLES, 16, width in clocks of the `pll_rst` pulse (watchdog only).

Ports:
- clk  input  1  50 MHz board clock, free-running and independent of the PLL.
- rst  input  1  synchronous, active-high reset.
- pll_locked  input  1  PLL LOCK, asynchronous to clk.
- sys_rst  output  1  registered, active-high reset for downstream logic.
- ready  output  1  registered; 1 only in RUN.
- lost_pulse  output  1  one-cycle pulse on each RUN→WAIT_LOCK transition.
- loss_count  output  8  saturating count of lock losses from RUN.
- state  output  2  current FSM state, for debug/LED use.
- pll_rst  output  1  PLL reset request; constant 0 without the watchdog.

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - `rst` is synchronous and active-high, and dominates everything, including mid-sequence.
- Values while `rst` is high:
  - synchronizer flops 0; state=WAIT_LOCK(1); counters 0.
  - sys_rst=1, ready=0, lost_pulse=0, loss_count=0, pll_rst=0.
- Synchronizer:
  - `pll_locked` passes through SYNC_STAGES flops; the last stage is lock_s.
  - No other logic samples `pll_locked`.
- States (encoding):
  - IDLE=0: unused after reset; transitions to WAIT_LOCK.
  - WAIT_LOCK=1, STABLE=2, PLL_RST=3.
  - RUN is STABLE with the stable counter done. It is encoded internally; `state` reports 2, and `ready` distinguishes it from STABLE.
- WAIT_LOCK:
  - sys_rst=1.
  - lock_s=1 → STABLE next edge, with stable_cnt=0.
- STABLE:
  - stable_cnt increments each cycle while lock_s=1.
  - lock_s=0 → WAIT_LOCK and stable_cnt cleared. loss_count is not incremented, because this is a glitch before release.
  - stable_cnt==STABLE_CYCLES-1 with lock_s=1 → RUN.
- RUN:
  - sys_rst=0, ready=1.
  - lock_s=0 → WAIT_LOCK. sys_rst=1 and ready=0 on the same edge; lost_pulse=1 for exactly that cycle.
  - loss_count increments, saturating at 255.
- Output timing:
  - sys_rst and ready are registered from next-state, so they change on the same edge as the state.
- Latency:
  - Release: sys_rst falls on the (SYNC_STAGES+STABLE_CYCLES)th edge after the first edge that samples `pll_locked`=1, given lock stays high.
  - Reassertion: sys_rst rises on the SYNC_STAGES-th edge after the first edge that samples `pll_locked`=0.
- Counter widths:
  - stable_cnt is wide enough for STABLE_CYCLES-1 and never wraps.
  - timeout counter is wide enough for TIMEOUT_CYCLES-1.
- Boundary conditions:
  - `pll_locked` toggling every cycle never reaches RUN.
  - A drop exactly on the completing cycle (lock_s=0 when stable_cnt==STABLE_CYCLES-1) → WAIT_LOCK, not RUN.
  - loss_count at 255 stays 255; lost_pulse still fires.

Optional Feature:
- Macro: DVI_PLL_LOCK_WATCHDOG_EN.
- When defined:
  - In WAIT_LOCK a timeout counter increments each cycle; it clears on leaving WAIT_LOCK.
  - At TIMEOUT_CYCLES-1 → PLL_RST(3).
  - PLL_RST: pll_rst=1 and sys_rst=1 for PLL_RST_CYCLES cycles, then → WAIT_LOCK with the timeout counter cleared. lock_s is ignored in PLL_RST.
- When undefined:
  - State 3 is unreachable; pll_rst is tied 0.
  - TIMEOUT_CYCLES and PLL_RST_CYCLES are unused.
  - WAIT_LOCK waits indefinitely.

Test Plan:
- Test parameters: SYNC_STAGES=2, STABLE_CYCLES=8, TIMEOUT_CYCLES=20, PLL_RST_CYCLES=4.
- Reset release: rst high 3 cycles then low, pll_locked=0 → sys_rst=1, ready=0, state=1, loss_count=0 indefinitely (watchdog off).
- Clean lock: pll_locked rises and stays high, first sampled at edge E → sys_rst falls and ready rises at E+10; state=2; lost_pulse never asserted.
- Pre-release glitch: pll_locked high 5 cycles, low 1 cycle, high again → no release at the original E+10; release 10 edges after the re-sampled rise; loss_count=0.
- Loss in RUN (three parts):
  - From RUN, pll_locked low sampled at edge F → sys_rst=1, ready=0, lost_pulse=1 at F+2 only; loss_count=1.
  - Relock then releases again after 10 edges.
  - Repeating the loss 300 times → loss_count=255.
- Mid-sequence reset: rst asserted in STABLE with stable_cnt=5 → next edge state=1, counters 0, sys_rst=1; after rst drops, a full 10-edge release is required.
- Watchdog (DVI_PLL_LOCK_WATCHDOG_EN defined): pll_locked held 0 → pll_rst high for exactly 4 cycles after 20 WAIT_LOCK cycles, repeating every 24 cycles; sys_rst stays 1. Without the macro, pll_rst stays 0.

Source files
------------

// File: rtl/dvi_pll_lock_supervisor_if.sv
// Lock-supervisor signal bundle between the PLL/board wrapper and the supervisor.
// slave = supervisor side, master = wrapper/PLL side.
interface dvi_pll_lock_supervisor_if;
    logic       pll_locked;
    logic       sys_rst;
    logic       ready;
    logic       lost_pulse;
    logic [7:0] loss_count;
    logic [1:0] state;
    logic       pll_rst;

    modport master (
        output pll_locked,
        input  sys_rst, ready, lost_pulse, loss_count, state, pll_rst
    );

    modport slave (
        input  pll_locked,
        output sys_rst, ready, lost_pulse, loss_count, state, pll_rst
    );
endinterface

// File: rtl/dvi_pll_lock_supervisor.sv
// DVI PLL lock supervisor: synchronizes LOCK, sequences sys_rst release/reassertion, counts losses.
// Optional PLL-reset watchdog enabled by defining DVI_PLL_LOCK_WATCHDOG_EN.
module dvi_pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 50000,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int PLL_RST_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    dvi_pll_lock_supervisor_if.slave     sup_if
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_PLLRST = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;

    localparam int STABLE_W = $clog2(STABLE_CYCLES);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 2 || TIMEOUT_CYCLES < 1 || PLL_RST_CYCLES < 1) begin : g_param_check
        $error("dvi_pll_lock_supervisor: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [2:0]             state_q, state_d;
    logic [STABLE_W-1:0]    stable_cnt_q, stable_cnt_d;
    logic                   sys_rst_q, ready_q, lost_q, lost_d;
    logic [7:0]             loss_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], sup_if.pll_locked};
    end
    assign lock_s = sync_q[SYNC_STAGES-1];

`ifdef DVI_PLL_LOCK_WATCHDOG_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PR_W = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PR_W-1:0] PR_LAST = PR_W'(PLL_RST_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [PR_W-1:0] pr_cnt_q, pr_cnt_d;
    logic            pll_rst_q;
`endif

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        case (state_q)
            S_IDLE: state_d = S_WAIT;
            S_WAIT: begin
                if (lock_s) begin
                    state_d      = S_STABLE;
                    stable_cnt_d = '0;
                end
`ifdef DVI_PLL_LOCK_WATCHDOG_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d = S_PLLRST;
                end
`endif
            end
            S_STABLE: begin
                // A drop on the completing cycle still counts as a pre-release glitch.
                if (!lock_s) begin
                    state_d      = S_WAIT;
                    stable_cnt_d = '0;
                end else if (stable_cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                end else begin
                    stable_cnt_d = stable_cnt_q + STABLE_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) state_d = S_WAIT;
            end
`ifdef DVI_PLL_LOCK_WATCHDOG_EN
            S_PLLRST: begin
                if (pr_cnt_q == PR_LAST) state_d = S_WAIT;
            end
`endif
            default: state_d = S_WAIT;
        endcase
    end

    assign lost_d = (state_q == S_RUN) && (state_d == S_WAIT);

    // Outputs register off next-state so they move on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT;
            stable_cnt_q <= '0;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            lost_q       <= 1'b0;
            loss_q       <= '0;
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            sys_rst_q    <= (state_d != S_RUN);
            ready_q      <= (state_d == S_RUN);
            lost_q       <= lost_d;
            if (lost_d && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
        end
    end

`ifdef DVI_PLL_LOCK_WATCHDOG_EN
    assign to_cnt_d = (state_q == S_WAIT && state_d == S_WAIT) ? to_cnt_q + TO_W'(1) : '0;
    assign pr_cnt_d = (state_q == S_PLLRST && state_d == S_PLLRST) ? pr_cnt_q + PR_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q  <= '0;
            pr_cnt_q  <= '0;
            pll_rst_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            pr_cnt_q  <= pr_cnt_d;
            pll_rst_q <= (state_d == S_PLLRST);
        end
    end
    assign sup_if.pll_rst = pll_rst_q;
`else
    assign sup_if.pll_rst = 1'b0;
`endif

    assign sup_if.sys_rst    = sys_rst_q;
    assign sup_if.ready      = ready_q;
    assign sup_if.lost_pulse = lost_q;
    assign sup_if.loss_count = loss_q;
    assign sup_if.state      = (state_q == S_RUN) ? 2'd2 : state_q[1:0];
endmodule
